// File: rtl/hx711_multi_reader.sv
// hx711_multi_reader: reads NUM_CH HX711 load-cell ADCs in lockstep over one
// shared SCK, averages 2^AVG_LOG2 conversions per channel and presents signed
// 24-bit samples with a one-cycle valid strobe. Optional build macro
// HX711_POWERDOWN_EN holds SCK high in IDLE (chip power-down) and inserts a
// wake delay before waiting for data-ready.
module hx711_multi_reader #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SCK_HALF_CYCLES = 50,
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 25000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             gain_sel,
    input  logic [NUM_CH-1:0]      hx711_dt,
    output logic                   hx711_sck,
    output logic [NUM_CH*24-1:0]   sample_data,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   timeout
);
    localparam int unsigned AW = 24 + AVG_LOG2;
    localparam int unsigned HW = $clog2(SCK_HALF_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = AVG_LOG2 + 1;
`ifdef HX711_POWERDOWN_EN
    localparam int unsigned WAKE_CYCLES = 120 * SCK_HALF_CYCLES;
    localparam int unsigned WW = $clog2(WAKE_CYCLES);
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAKE, ST_WAIT_RDY, ST_SCK_HIGH, ST_SCK_LOW, ST_ACCUM
    } state_t;

    state_t                        state_q, state_d;
    logic [NUM_CH-1:0]             dt_meta_q, dt_sync_q;
    logic [HW-1:0]                 half_q, half_d;
    logic [4:0]                    pulse_q, pulse_d;
    logic [4:0]                    npulse_q, npulse_d;
    logic [1:0]                    gain_q, gain_d;
    logic                          primed_q, primed_d;
    logic                          discard_q, discard_d;
    logic [NUM_CH-1:0][23:0]       shreg_q, shreg_d;
    logic [NUM_CH-1:0][AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [TW-1:0]                 to_cnt_q, to_cnt_d;
    logic                          timeout_q, timeout_d;
    logic [NUM_CH*24-1:0]          data_q, data_d;
    logic                          valid_q, valid_d;
    logic                          sck_q, sck_d;
`ifdef HX711_POWERDOWN_EN
    logic [WW-1:0]                 wake_q, wake_d;
`endif

    logic       ready;
    logic       half_last;
    logic [1:0] gnorm;

    assign ready     = ~|dt_sync_q;
    assign half_last = (half_q == HW'(SCK_HALF_CYCLES - 1));
    assign gnorm     = (gain_sel == 2'd3) ? 2'd0 : gain_sel;

    assign hx711_sck    = sck_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == ST_SCK_HIGH) || (state_q == ST_SCK_LOW);
    assign timeout      = timeout_q;

    // Next-state, datapath and output decode for the conversion sequencer.
    always_comb begin
        logic signed [AW-1:0] sum;
        logic signed [AW-1:0] sum_sh;
        sum       = '0;
        sum_sh    = '0;
        state_d   = state_q;
        half_d    = half_q;
        pulse_d   = pulse_q;
        npulse_d  = npulse_q;
        gain_d    = gain_q;
        primed_d  = primed_q;
        discard_d = discard_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        to_cnt_d  = '0;
        timeout_d = timeout_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef HX711_POWERDOWN_EN
        wake_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
`ifdef HX711_POWERDOWN_EN
                    // chips were powered down; their first result is stale
                    primed_d = 1'b0;
                    state_d  = ST_WAKE;
`else
                    state_d  = ST_WAIT_RDY;
`endif
                end
            end
            ST_WAKE: begin
`ifdef HX711_POWERDOWN_EN
                wake_d = wake_q + 1'b1;
                if (wake_q == WW'(WAKE_CYCLES - 1)) state_d = ST_WAIT_RDY;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_WAIT_RDY: begin
                to_cnt_d = (to_cnt_q == TW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + 1'b1;
                if (to_cnt_d == TW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ready) begin
                    case (gnorm)
                        2'd1:    npulse_d = 5'd26;
                        2'd2:    npulse_d = 5'd27;
                        default: npulse_d = 5'd25;
                    endcase
                    discard_d = !primed_q || (gnorm != gain_q);
                    gain_d    = gnorm;
                    primed_d  = 1'b1;
                    pulse_d   = '0;
                    half_d    = '0;
                    shreg_d   = '0;
                    state_d   = ST_SCK_HIGH;
                end
            end
            ST_SCK_HIGH: begin
                if (half_last) begin
                    half_d  = '0;
                    state_d = ST_SCK_LOW;
                    if (pulse_q < 5'd24) begin
                        for (int unsigned ch = 0; ch < NUM_CH; ch++)
                            shreg_d[ch] = {shreg_q[ch][22:0], dt_sync_q[ch]};
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_SCK_LOW: begin
                if (half_last) begin
                    half_d  = '0;
                    pulse_d = pulse_q + 1'b1;
                    state_d = (pulse_d < npulse_q) ? ST_SCK_HIGH : ST_ACCUM;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                if (!discard_q) begin
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                        sum = $signed(acc_q[ch]) + AW'($signed(shreg_q[ch]));
                        if (cnt_q == CW'((1 << AVG_LOG2) - 1)) begin
                            sum_sh             = sum >>> AVG_LOG2;
                            data_d[ch*24 +: 24] = sum_sh[23:0];
                            acc_d[ch]          = '0;
                        end else begin
                            acc_d[ch] = sum;
                        end
                    end
                    if (cnt_q == CW'((1 << AVG_LOG2) - 1)) begin
                        cnt_d     = '0;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                state_d = enable ? ST_WAIT_RDY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef HX711_POWERDOWN_EN
        sck_d = (state_d == ST_SCK_HIGH) || (state_d == ST_IDLE);
`else
        sck_d = (state_d == ST_SCK_HIGH);
`endif
    end

    // State register, DOUT synchronizer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dt_meta_q <= '1;
            dt_sync_q <= '1;
            half_q    <= '0;
            pulse_q   <= '0;
            npulse_q  <= '0;
            gain_q    <= '0;
            primed_q  <= 1'b0;
            discard_q <= 1'b0;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sck_q     <= 1'b0;
`ifdef HX711_POWERDOWN_EN
            wake_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dt_meta_q <= hx711_dt;
            dt_sync_q <= dt_meta_q;
            half_q    <= half_d;
            pulse_q   <= pulse_d;
            npulse_q  <= npulse_d;
            gain_q    <= gain_d;
            primed_q  <= primed_d;
            discard_q <= discard_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sck_q     <= sck_d;
`ifdef HX711_POWERDOWN_EN
            wake_q    <= wake_d;
`endif
        end
    end

endmodule

// File: tb/tb_hx711_multi_reader.sv
// Directed bench for hx711_multi_reader with a per-channel HX711 serial model
// and a scoreboard of expected averaged samples. Honours HX711_POWERDOWN_EN.
module tb_hx711_multi_reader;
    localparam int NCH  = 2;
    localparam int HALF = 4;
    localparam int AVG  = 2;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  gain_sel = 2'd0;
    logic [1:0]  dt = 2'b11;
    logic        sck, valid, busy, tmo;
    logic [47:0] data;

    always #5 clk = ~clk;

    hx711_multi_reader #(
        .NUM_CH(NCH), .SCK_HALF_CYCLES(HALF), .AVG_LOG2(AVG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .gain_sel(gain_sel),
        .hx711_dt(dt), .hx711_sck(sck), .sample_data(data),
        .sample_valid(valid), .busy(busy), .timeout(tmo)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [47:0] exp_q[$];
    int          rises = 0, train_rises = 0, hi_len = 0, bad_hi = 0, bad_per = 0;
    int          cyc = 0, last_rise = 0, first_rise = 0, r;
    logic        sck_prev = 1'b0, valid_prev = 1'b0;
`ifdef HX711_POWERDOWN_EN
    int          fall_cyc = 0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock, sampled on the falling edge; tracks SCK shape and scores strobes.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sck && !sck_prev) begin
            if (train_rises > 0 && (cyc - last_rise) != 2 * HALF) bad_per++;
            rises++;
            train_rises++;
            last_rise = cyc;
        end
        if (sck && busy) hi_len++;
        if (!sck && sck_prev) begin
            if (busy && hi_len != HALF) bad_hi++;
`ifdef HX711_POWERDOWN_EN
            if (!busy) fall_cyc = cyc;
`endif
            hi_len = 0;
        end
        sck_prev = sck;
        if (valid) begin
            chk("valid_one_cycle", valid_prev, 0);
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_valid: observed strobe with data %0h, expected none", data);
            end
            if (exp_q.size() != 0) chk("sample_data", data, exp_q.pop_front());
        end
        valid_prev = valid;
    endtask

    task automatic wait_rise();
        int r0 = rises;
        for (int i = 0; i < 3000 && rises == r0; i++) tick();
        chk("sck_rise_seen", rises != r0, 1);
    endtask

    // One full conversion: signal ready, serve bits MSB-first on each SCK rise.
    task automatic conv(input logic [23:0] v0, input logic [23:0] v1, input int np);
        int r0 = rises;
        train_rises = 0;
        dt = 2'b00;
        for (int p = 0; p < np; p++) begin
            wait_rise();
            if (p == 0) first_rise = cyc;
            dt[0] = (p < 24) ? v0[23-p] : 1'b1;
            dt[1] = (p < 24) ? v1[23-p] : 1'b1;
        end
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("train_end", busy, 0);
        chk("pulse_count", rises - r0, np);
        chk("sck_high_width_errs", bad_hi, 0);
        chk("sck_period_errs", bad_per, 0);
        dt = 2'b11;
        repeat (3) tick();
    endtask

    initial begin
        repeat (4) tick();
        chk("rst_sck", sck, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_data", data, 0);
        reset = 1'b0;
        repeat (2) tick();
`ifdef HX711_POWERDOWN_EN
        chk("idle_sck_powerdown", sck, 1);
`else
        chk("idle_sck", sck, 0);
`endif
        enable = 1'b1;

        // first conversion after reset is dropped, then four identical ones
        conv(24'h000123, 24'hFFFF00, 25);
`ifdef HX711_POWERDOWN_EN
        chk("wake_delay_ok", (first_rise - fall_cyc) >= 120 * HALF + 2, 1);
`endif
        repeat (3) conv(24'h000123, 24'hFFFF00, 25);
        exp_q.push_back({24'hFFFF00, 24'h000123});
        conv(24'h000123, 24'hFFFF00, 25);
        chk("sb_drained_basic", exp_q.size(), 0);

        // averaging with floor: 406/4 -> 101, -7/4 -> -2
        conv(24'd100, 24'hFFFFFF, 25);
        conv(24'd101, 24'hFFFFFE, 25);
        conv(24'd102, 24'hFFFFFE, 25);
        exp_q.push_back({24'hFFFFFE, 24'd101});
        conv(24'd103, 24'hFFFFFE, 25);
        chk("sb_drained_avg", exp_q.size(), 0);

        // gain 0 -> 2: 27 pulses, first one dropped; full-scale extremes
        gain_sel = 2'd2;
        conv(24'h111111, 24'h222222, 27);
        repeat (3) conv(24'h7FFFFF, 24'h800000, 27);
        exp_q.push_back({24'h800000, 24'h7FFFFF});
        conv(24'h7FFFFF, 24'h800000, 27);
        chk("sb_drained_gain2", exp_q.size(), 0);

        // gain 2 -> 3 (chA/128): dropped, then 38/4 -> 9 and -38/4 -> -10
        gain_sel = 2'd3;
        conv(24'd5, 24'd5, 25);
        conv(24'd8, 24'hFFFFF8, 25);
        conv(24'd9, 24'hFFFFF7, 25);
        conv(24'd10, 24'hFFFFF6, 25);
        exp_q.push_back({24'hFFFFF6, 24'd9});
        conv(24'd11, 24'hFFFFF5, 25);
        chk("sb_drained_gain3", exp_q.size(), 0);

        // ready timeout: ch1 stays busy
        dt = 2'b10;
        r = rises;
        repeat (975) tick();
        chk("timeout_not_yet", tmo, 0);
        repeat (45) tick();
        chk("timeout_set", tmo, 1);
        chk("timeout_no_sck", rises - r, 0);
        chk("timeout_sck_low", sck, 0);
        conv(24'd0, 24'd1, 25);
        conv(24'd0, 24'd2, 25);
        conv(24'd0, 24'd3, 25);
        chk("timeout_sticky", tmo, 1);
        exp_q.push_back({24'd2, 24'd0});
        conv(24'd3, 24'd4, 25);
        chk("timeout_cleared", tmo, 0);
        chk("sb_drained_timeout", exp_q.size(), 0);

        // partial accumulation then reset during the 10th SCK high phase
        conv(24'd1000, 24'd1000, 25);
        conv(24'd1000, 24'd1000, 25);
        train_rises = 0;
        dt = 2'b00;
        repeat (10) wait_rise();
        reset = 1'b1;
        tick();
        chk("midtrain_rst_sck", sck, 0);
        chk("midtrain_rst_busy", busy, 0);
        tick();
        dt = 2'b11;
        reset = 1'b0;
        tick();
        conv(24'd7, 24'd7, 25);
        repeat (3) conv(24'd40, 24'hFFFFD8, 25);
        exp_q.push_back({24'hFFFFD8, 24'd40});
        conv(24'd40, 24'hFFFFD8, 25);
        chk("sb_drained_reset", exp_q.size(), 0);

        // enable low: back to IDLE, no trains even with ready asserted
        enable = 1'b0;
        repeat (20) tick();
        dt = 2'b00;
        r = rises;
        repeat (200) tick();
        chk("idle_no_sck", rises - r, 0);
        chk("idle_not_busy", busy, 0);
`ifdef HX711_POWERDOWN_EN
        chk("idle_sck_end", sck, 1);
`else
        chk("idle_sck_end", sck, 0);
`endif
        dt = 2'b11;
        chk("sb_final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
